// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a multicycle CPU: IDLE -> WAIT (LATENCY cycles) -> RESP.
// Optional macro MEM_MISALIGN_CHECK_EN turns misaligned accesses into an err pulse with no array access.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        wr_done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  resp_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic [AW-1:0]   word_idx;
  logic            misaligned;
  logic            commit;
  logic            unused_addr;

  assign req        = MemRead | MemWrite;
  assign word_idx   = addr_q[AW+1:2];
  assign resp_state = state;
  // Bits above the word index alias onto the array and are deliberately dropped.
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The array access happens on the WAIT->RESP edge.
  assign commit = (state == WAIT) && (cnt == '0) && !misaligned;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    state_nxt = (cnt == '0) ? RESP : WAIT;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    rdata_valid = 1'b0;
    wr_done     = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: busy = req;
      WAIT: busy = 1'b1;
      RESP: begin
        rdata_valid = !write_q && !misaligned;
        wr_done     = write_q && !misaligned;
        err         = misaligned;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q  <= addr[AW+1:0];
          wdata_q <= wdata;
          write_q <= MemWrite;  // simultaneous read+write is taken as a write
          cnt     <= CW'(LATENCY - 1);
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (commit && !write_q) rdata <= mem[word_idx];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive rst, and rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && write_q) mem[word_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized accesses
// compared against an array-based reference model.
module tb_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        wr_done;
  logic        busy;
  logic        err;
  logic [1:0]  resp_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .wr_done(wr_done), .busy(busy), .err(err), .resp_state(resp_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, {30'd0, resp_state}, 32'd0);
    check({tag, "_valid"}, {31'd0, rdata_valid}, 32'd0);
    check({tag, "_wrdone"}, {31'd0, wr_done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_rdata"}, rdata, model_rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_rdata = '0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_idle_outputs("rst");
    rst = 1'b0;
  endtask

  // One complete access, checked cycle by cycle against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit is_wr;
    bit is_rd;
    bit mis;
    int idx;
    is_wr = wr;
    is_rd = rd && !wr;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    idx = int'((a >> 2) % DEPTH);

    @(negedge clk);
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    #1 check("busy_req", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0; addr = $urandom; wdata = $urandom;

    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      check("wait_state", {30'd0, resp_state}, 32'd1);
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_pulses", {29'd0, rdata_valid, wr_done, err}, 32'd0);
    end

    if (!mis) begin
      if (is_wr)      model_mem[idx] = d;
      else if (is_rd) model_rdata = model_mem[idx];
    end

    @(negedge clk);
    check("resp_state", {30'd0, resp_state}, 32'd2);
    check("resp_busy", {31'd0, busy}, 32'd0);
    check("resp_valid", {31'd0, rdata_valid}, {31'd0, is_rd && !mis});
    check("resp_wrdone", {31'd0, wr_done}, {31'd0, is_wr && !mis});
    check("resp_err", {31'd0, err}, {31'd0, mis});
    check("resp_rdata", rdata, model_rdata);

    @(negedge clk);
    check_idle_outputs("post");
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    do_reset();

    // Basic write then read of the same word, with rdata hold afterwards.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check("read_deadbeef", rdata, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rdata_hold", rdata, 32'hDEADBEEF);
    end

    // Read+write together is a write.
    access(1'b1, 1'b1, 32'h20, 32'h1234);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    check("rw_as_write", rdata, 32'h1234);

    // High address bits alias.
    access(1'b0, 1'b1, 32'h400, 32'hCAFE);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    check("wrap_read", rdata, 32'hCAFE);

    // Reset in the first WAIT cycle aborts the write.
    access(1'b0, 1'b1, 32'h30, 32'h55);
    @(negedge clk);
    MemWrite = 1'b1; addr = 32'h30; wdata = 32'h99;
    @(posedge clk);
    #1 MemWrite = 1'b0;
    @(negedge clk);
    check("abort_in_wait", {30'd0, resp_state}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    check_idle_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_wrdone", {31'd0, wr_done}, 32'd0);
      check("abort_idle", {30'd0, resp_state}, 32'd0);
    end
    access(1'b1, 1'b0, 32'h30, 32'h0);
    check("abort_mem_kept", rdata, 32'h55);

    // Misaligned read: err with the check enabled, mem[4] otherwise.
    access(1'b1, 1'b0, 32'h13, 32'h0);

    // Fill the array, then randomized traffic.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom);
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the memory array (power of two, >= 4).
REQ-002 Parameter LATENCY, default 2, number of WAIT cycles per access (>= 1).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 MemRead  input  1  read request strobe from the multicycle controller.
REQ-006 MemWrite  input  1  write request strobe from the multicycle controller.
REQ-007 addr  input  32  byte address (IorD-selected PC or ALUOut).
REQ-008 wdata  input  32  store data (register B).
REQ-009 rdata  output  32  read data, registered.
REQ-010 rdata_valid  output  1  one-cycle pulse: rdata holds the completed read.
REQ-011 wr_done  output  1  one-cycle pulse: write committed to the array.
REQ-012 busy  output  1  high while an accepted access is pending; controller stalls on it.
REQ-013 err  output  1  one-cycle misalignment error pulse (see Configuration).
REQ-014 resp_state  output  2  current FSM state encoding, for debug.

Function
REQ-015 The FSM SHALL have states IDLE=2'b00, WAIT=2'b01, RESP=2'b10; encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-016 In IDLE, a request (MemRead or MemWrite high) SHALL be accepted on the edge: addr, wdata, and the operation type latched; cnt loaded with LATENCY-1; next state WAIT.
REQ-017 MemRead and MemWrite both high in IDLE SHALL be accepted as a write; the read is dropped.
REQ-018 In WAIT, busy SHALL be 1; cnt decrements each cycle; at cnt==0 next state is RESP, giving exactly LATENCY cycles in WAIT.
REQ-019 On the WAIT->RESP edge, a read SHALL load rdata from mem[latched addr word index], and a write SHALL store latched wdata into that word.
REQ-020 In RESP, rdata_valid (read) or wr_done (write) SHALL be 1 for that single cycle; busy SHALL be 0; next state IDLE unconditionally.
REQ-021 Requests presented in WAIT or RESP SHALL be ignored, not queued; the controller holds strobes until busy falls and resamples in IDLE.
REQ-022 The request-to-response latency SHALL be LATENCY+1 cycles from the accepting edge to the first RESP cycle.
REQ-023 busy SHALL also be 1 combinationally in IDLE while a request is present, so the controller stalls in the same cycle.
REQ-024 The word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (aliasing wrap-around).
REQ-025 rdata SHALL hold its last value outside rdata_valid cycles; a write SHALL NOT change rdata.

Reset
REQ-026 With rst high at an edge: state=IDLE, cnt=0, rdata=0, rdata_valid=0, wr_done=0, err=0, busy=0, latched address/data/type=0.
REQ-027 Reset during WAIT SHALL abort the access; a pending write SHALL NOT be committed.
REQ-028 Memory array contents SHALL NOT be reset.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN: when defined, an accepted access with addr[1:0]!=0 proceeds through WAIT; in RESP it asserts err=1, performs no array access, and leaves rdata_valid, wr_done and rdata unchanged/0.
REQ-030 When MEM_MISALIGN_CHECK_EN is not defined, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-031 Reset, then MemWrite with addr=0x10, wdata=0xDEADBEEF (LATENCY=2) -> busy for 3 cycles, wr_done pulses at the 3rd cycle after acceptance, mem[4]=0xDEADBEEF.
REQ-032 Then MemRead with addr=0x10 -> rdata=0xDEADBEEF with rdata_valid exactly 1 cycle, 3 cycles after acceptance; rdata still 0xDEADBEEF 5 cycles later.
REQ-033 MemRead and MemWrite both high, addr=0x20, wdata=0x1234 -> wr_done pulses, rdata_valid stays 0, mem[8]=0x1234.
REQ-034 Write 0xCAFE to addr=0x400 (DEPTH=256) -> a read of addr=0x0 returns 0xCAFE (wrap-around).
REQ-035 Write to addr=0x30 with rst pulsed during the 1st WAIT cycle -> FSM in IDLE, wr_done never pulses, mem[12] unchanged.
REQ-036 With MEM_MISALIGN_CHECK_EN, MemRead addr=0x13 -> err=1 for one cycle in RESP, rdata_valid=0; without the macro -> returns mem[4] with rdata_valid=1.
